// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the core-memory port arbiter.
// State encoding, requester ids and the word-address width helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  // RAM word-address bits for a given byte-address width
  function automatic int unsigned word_addr_w(input int unsigned addr_w);
    return addr_w - 32'd2;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store and RAM-side signals of the core-memory arbiter.
// slave = arbiter view, master = pipeline/RAM environment view.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 14
);
  localparam int unsigned WA_W = word_addr_w(ADDR_W);

  logic             i_req_valid;
  logic             i_req_ready;
  logic [31:0]      i_req_addr;
  logic             i_resp_valid;
  logic             i_resp_ready;
  logic [31:0]      i_resp_data;

  logic             d_req_valid;
  logic             d_req_ready;
  logic [31:0]      d_req_addr;
  logic [3:0]       d_req_we;
  logic [31:0]      d_req_wdata;
  logic             d_resp_valid;
  logic             d_resp_ready;
  logic [31:0]      d_resp_data;

  logic             mem_en;
  logic [3:0]       mem_we;
  logic [WA_W-1:0]  mem_addr;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;

  logic             busy;

  modport slave (
    input  i_req_valid, i_req_addr, i_resp_ready,
    output i_req_ready, i_resp_valid, i_resp_data,
    input  d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_resp_ready,
    output d_req_ready, d_resp_valid, d_resp_data,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output i_req_valid, i_req_addr, i_resp_ready,
    input  i_req_ready, i_resp_valid, i_resp_data,
    output d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_resp_ready,
    input  d_req_ready, d_resp_valid, d_resp_data,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch (I) and load/store (D).
// MEM_ARB_RR_EN: contested grants follow the pref input (round-robin pointer).
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter bit D_PRIO = 1'b1
) (
  input  logic i_valid,
  input  logic d_valid,
`ifdef MEM_ARB_RR_EN
  input  logic pref,
`endif
  output logic win
);

  always_comb begin
    win = REQ_I;
    if (i_valid && d_valid) begin
`ifdef MEM_ARB_RR_EN
      win = pref;
`else
      win = D_PRIO ? REQ_D : REQ_I;
`endif
    end else if (d_valid) begin
      win = REQ_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported core RAM between instruction fetch and load/store.
// Optional MEM_ARB_RR_EN replaces fixed D_PRIO priority with round-robin.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 14,
  parameter bit          D_PRIO = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned WA_W = word_addr_w(ADDR_W);

  state_e          state_q, state_d;
  logic            win_q;
  logic            wr_q;
  logic [31:0]     hold_q;
  logic            win;
  logic            accept;
  logic            resp_valid;
  logic [31:0]     resp_data;
  logic [31:0]     resp_word;
  logic            resp_ready;
  logic            i_ready;
  logic            d_ready;
  logic            mem_en;
  logic [3:0]      mem_we;
  logic [WA_W-1:0] mem_addr;
  logic [31:0]     mem_wdata;
  logic            unused_addr_bits;

`ifdef MEM_ARB_RR_EN
  // Next contested grant goes to this requester; flips away from every winner
  logic pref_q;
`endif

  mem_arb_pick #(.D_PRIO(D_PRIO)) u_pick (
    .i_valid (bus.i_req_valid),
    .d_valid (bus.d_req_valid),
`ifdef MEM_ARB_RR_EN
    .pref    (pref_q),
`endif
    .win     (win)
  );

  assign resp_word  = wr_q ? 32'h0 : bus.mem_rdata;
  assign resp_ready = (win_q == REQ_D) ? bus.d_resp_ready : bus.i_resp_ready;

  // Next state, accept-cycle RAM drive and response muxing
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    i_ready    = 1'b0;
    d_ready    = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 4'h0;
    mem_addr   = '0;
    mem_wdata  = 32'h0;
    resp_valid = 1'b0;
    resp_data  = 32'h0;
    unique case (state_q)
      IDLE: begin
        // resetn gate keeps every output low while reset is held
        if (resetn && (bus.i_req_valid || bus.d_req_valid)) begin
          accept    = 1'b1;
          mem_en    = 1'b1;
          mem_wdata = bus.d_req_wdata;
          state_d   = RESP;
          if (win == REQ_D) begin
            d_ready  = 1'b1;
            mem_we   = bus.d_req_we;
            mem_addr = bus.d_req_addr[ADDR_W-1:2];
          end else begin
            i_ready  = 1'b1;
            mem_addr = bus.i_req_addr[ADDR_W-1:2];
          end
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_data  = resp_word;
        state_d    = resp_ready ? IDLE : HOLD;
      end
      HOLD: begin
        resp_valid = 1'b1;
        resp_data  = hold_q;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      win_q   <= REQ_I;
      wr_q    <= 1'b0;
      hold_q  <= 32'h0;
`ifdef MEM_ARB_RR_EN
      pref_q  <= REQ_I;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        win_q  <= win;
        wr_q   <= (win == REQ_D) && (|bus.d_req_we);
`ifdef MEM_ARB_RR_EN
        pref_q <= ~win;
`endif
      end
      if (state_q == RESP) hold_q <= resp_word;
    end
  end

  assign bus.i_req_ready  = i_ready;
  assign bus.d_req_ready  = d_ready;
  assign bus.i_resp_valid = resp_valid && (win_q == REQ_I);
  assign bus.d_resp_valid = resp_valid && (win_q == REQ_D);
  assign bus.i_resp_data  = (win_q == REQ_I) ? resp_data : 32'h0;
  assign bus.d_resp_data  = (win_q == REQ_D) ? resp_data : 32'h0;
  assign bus.mem_en       = mem_en;
  assign bus.mem_we       = mem_we;
  assign bus.mem_addr     = mem_addr;
  assign bus.mem_wdata    = mem_wdata;
  assign bus.busy         = (state_q != IDLE);

  // Sub-word and out-of-range address bits are deliberately ignored
  assign unused_addr_bits = ^{bus.i_req_addr[31:ADDR_W], bus.i_req_addr[1:0],
                              bus.d_req_addr[31:ADDR_W], bus.d_req_addr[1:0]};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, multi-cycle corner sequences and a
// randomized transaction-level scoreboard (default fixed-priority build, D_PRIO=1).
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W = 14;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .D_PRIO(1'b1)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // Synchronous RAM: data appears the cycle after mem_en
  logic [31:0] ram [0:4095];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_we[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  typedef struct {
    logic        iv;
    logic [31:0] ia;
    logic        dv;
    logic [31:0] da;
    logic [3:0]  we;
    logic [31:0] wd;
    logic        exp_d;
    logic [11:0] exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  int total = 0;
  int bad   = 0;
  logic [31:0] model [0:15];
  vec_t tbl [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_req_valid  = 1'b0;
    bus.i_req_addr   = 32'h0;
    bus.d_req_valid  = 1'b0;
    bus.d_req_addr   = 32'h0;
    bus.d_req_we     = 4'h0;
    bus.d_req_wdata  = 32'h0;
    bus.i_resp_ready = 1'b1;
    bus.d_resp_ready = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_i_ready"},  32'(bus.i_req_ready),  32'h0);
    check({tag, "_d_ready"},  32'(bus.d_req_ready),  32'h0);
    check({tag, "_i_rvalid"}, 32'(bus.i_resp_valid), 32'h0);
    check({tag, "_d_rvalid"}, 32'(bus.d_resp_valid), 32'h0);
    check({tag, "_i_rdata"},  bus.i_resp_data,       32'h0);
    check({tag, "_d_rdata"},  bus.d_resp_data,       32'h0);
    check({tag, "_mem_en"},   32'(bus.mem_en),       32'h0);
    check({tag, "_mem_we"},   32'(bus.mem_we),       32'h0);
    check({tag, "_mem_addr"}, 32'(bus.mem_addr),     32'h0);
    check({tag, "_mem_wdata"}, bus.mem_wdata,        32'h0);
    check({tag, "_busy"},     32'(bus.busy),         32'h0);
  endtask

  // One uncontested-or-contested transaction from IDLE with no back-pressure
  task automatic do_txn(input vec_t v);
    bus.i_req_valid  = v.iv;
    bus.i_req_addr   = v.ia;
    bus.d_req_valid  = v.dv;
    bus.d_req_addr   = v.da;
    bus.d_req_we     = v.we;
    bus.d_req_wdata  = v.wd;
    bus.i_resp_ready = 1'b1;
    bus.d_resp_ready = 1'b1;
    @(negedge clk);
    check("acc_i_ready", 32'(bus.i_req_ready), 32'(!v.exp_d));
    check("acc_d_ready", 32'(bus.d_req_ready), 32'(v.exp_d));
    check("acc_mem_en",  32'(bus.mem_en),      32'h1);
    check("acc_mem_addr", 32'(bus.mem_addr),   32'(v.exp_addr));
    check("acc_mem_we",  32'(bus.mem_we),      v.exp_d ? 32'(v.we) : 32'h0);
    if (v.exp_d) check("acc_mem_wdata", bus.mem_wdata, v.wd);
    check("acc_busy",    32'(bus.busy),        32'h0);
    tick();
    bus.i_req_valid = 1'b0;
    bus.d_req_valid = 1'b0;
    @(negedge clk);
    check("rsp_i_valid", 32'(bus.i_resp_valid), 32'(!v.exp_d));
    check("rsp_d_valid", 32'(bus.d_resp_valid), 32'(v.exp_d));
    check("rsp_data",    v.exp_d ? bus.d_resp_data : bus.i_resp_data, v.exp_data);
    check("rsp_other",   v.exp_d ? bus.i_resp_data : bus.d_resp_data, 32'h0);
    check("rsp_mem_en",  32'(bus.mem_en), 32'h0);
    check("rsp_busy",    32'(bus.busy),   32'h1);
    tick();
  endtask

  initial begin
    vec_t v;
    logic        i_pend, d_pend, busy_m, exp_side, winner;
    logic [31:0] ia, da, wd, exp_data, addr;
    logic [3:0]  we;
    logic [11:0] word;

    //          iv    ia            dv    da            we     wd            d     addr    data
    tbl[0]  = '{1'b0, 32'h0,        1'b1, 32'h10,       4'hF, 32'h00500093, 1'b1, 12'h004, 32'h0};
    tbl[1]  = '{1'b0, 32'h0,        1'b1, 32'h20,       4'hF, 32'h11223344, 1'b1, 12'h008, 32'h0};
    tbl[2]  = '{1'b1, 32'h80000010, 1'b0, 32'h0,        4'h0, 32'h0,        1'b0, 12'h004, 32'h00500093};
    tbl[3]  = '{1'b0, 32'h0,        1'b1, 32'h20,       4'h3, 32'hDEADBEEF, 1'b1, 12'h008, 32'h0};
    tbl[4]  = '{1'b0, 32'h0,        1'b1, 32'h20,       4'h0, 32'h0,        1'b1, 12'h008, 32'h1122BEEF};
    tbl[5]  = '{1'b1, 32'h10,       1'b1, 32'h22,       4'h0, 32'h0,        1'b1, 12'h008, 32'h1122BEEF};
    tbl[6]  = '{1'b1, 32'hFFFFC010, 1'b0, 32'h0,        4'h0, 32'h0,        1'b0, 12'h004, 32'h00500093};
    tbl[7]  = '{1'b0, 32'h0,        1'b1, 32'hFFC,      4'hF, 32'hCAFEF00D, 1'b1, 12'h3FF, 32'h0};
    tbl[8]  = '{1'b0, 32'h0,        1'b1, 32'hFFD,      4'h0, 32'h0,        1'b1, 12'h3FF, 32'hCAFEF00D};
    tbl[9]  = '{1'b0, 32'h0,        1'b1, 32'h10,       4'h4, 32'h00AB0000, 1'b1, 12'h004, 32'h0};
    tbl[10] = '{1'b1, 32'h10,       1'b1, 32'h10,       4'h0, 32'h0,        1'b1, 12'h004, 32'h00AB0093};
    tbl[11] = '{1'b1, 32'h10,       1'b0, 32'h0,        4'h0, 32'h0,        1'b0, 12'h004, 32'h00AB0093};
    tbl[12] = '{1'b1, 32'h20,       1'b0, 32'h0,        4'hF, 32'h0BADF00D, 1'b0, 12'h008, 32'h1122BEEF};
    tbl[13] = '{1'b0, 32'h0,        1'b1, 32'h20,       4'h0, 32'h0,        1'b1, 12'h008, 32'h1122BEEF};

    resetn = 1'b0;
    clear_inputs();
    #3;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    tick();

    for (int n = 0; n < 14; n++) do_txn(tbl[n]);

    // Contested: D wins, I keeps requesting and is granted two cycles later
    bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h20;
    bus.d_req_valid = 1'b1; bus.d_req_addr = 32'hFFC; bus.d_req_we = 4'h0;
    @(negedge clk);
    check("cont_d_ready", 32'(bus.d_req_ready), 32'h1);
    check("cont_i_ready", 32'(bus.i_req_ready), 32'h0);
    tick();
    bus.d_req_valid = 1'b0;
    @(negedge clk);
    check("cont_i_wait",  32'(bus.i_req_ready),  32'h0);
    check("cont_d_data",  bus.d_resp_data,       32'hCAFEF00D);
    tick();
    @(negedge clk);
    check("cont_i_grant", 32'(bus.i_req_ready),  32'h1);
    check("cont_i_addr",  32'(bus.mem_addr),     32'h8);
    tick();
    bus.i_req_valid = 1'b0;
    @(negedge clk);
    check("cont_i_rvalid", 32'(bus.i_resp_valid), 32'h1);
    check("cont_i_data",  bus.i_resp_data,       32'h1122BEEF);
    tick();

    // Back-pressure: D response stalled three cycles while I waits
    bus.d_req_valid = 1'b1; bus.d_req_addr = 32'h20; bus.d_resp_ready = 1'b0;
    @(negedge clk);
    check("bp_d_ready", 32'(bus.d_req_ready), 32'h1);
    tick();
    bus.d_req_valid = 1'b0;
    bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h10;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_rvalid",  32'(bus.d_resp_valid), 32'h1);
      check("bp_data",    bus.d_resp_data,       32'h1122BEEF);
      check("bp_i_ready", 32'(bus.i_req_ready),  32'h0);
      check("bp_mem_en",  32'(bus.mem_en),       32'h0);
      check("bp_busy",    32'(bus.busy),         32'h1);
      tick();
    end
    bus.d_resp_ready = 1'b1;
    @(negedge clk);
    check("bp_rel_data",  bus.d_resp_data,      32'h1122BEEF);
    check("bp_rel_iwait", 32'(bus.i_req_ready), 32'h0);
    tick();
    @(negedge clk);
    check("bp_idle_busy", 32'(bus.busy),        32'h0);
    check("bp_i_grant",   32'(bus.i_req_ready), 32'h1);
    tick();
    bus.i_req_valid = 1'b0;
    @(negedge clk);
    check("bp_i_data", bus.i_resp_data, 32'h00AB0093);
    tick();

    // Reset asserted while a response is held
    bus.d_req_valid = 1'b1; bus.d_req_addr = 32'h10; bus.d_resp_ready = 1'b0;
    tick();
    bus.d_req_valid = 1'b0;
    @(negedge clk);
    check("rst_resp", 32'(bus.d_resp_valid), 32'h1);
    tick();
    bus.i_req_valid = 1'b1; bus.i_req_addr = 32'h20;
    bus.d_req_valid = 1'b1; bus.d_req_addr = 32'h20;
    bus.d_req_we = 4'hF; bus.d_req_wdata = 32'h0BADF00D;
    #1;
    check("rst_hold_busy", 32'(bus.busy), 32'h1);
    check("rst_hold_data", bus.d_resp_data, 32'h00AB0093);
    resetn = 1'b0;
    #1;
    check_all_zero("rst_mid");
    @(negedge clk);
    check_all_zero("rst_held");
    clear_inputs();
    resetn = 1'b1;
    tick();
    v = '{1'b1, 32'h20, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 12'h008, 32'h1122BEEF};
    do_txn(v);

    // Seed words 0..15 for the randomized phase
    for (int k = 0; k < 16; k++) begin
      model[k] = 32'hA5A5A5A5 ^ (32'(k) * 32'h01010101);
      v = '{1'b0, 32'h0, 1'b1, 32'(k) << 2, 4'hF, model[k], 1'b1, 12'(k), 32'h0};
      do_txn(v);
    end

    // Randomized traffic against a transaction-level scoreboard
    i_pend = 1'b0; d_pend = 1'b0; busy_m = 1'b0; exp_side = 1'b0; exp_data = 32'h0;
    ia = 32'h0; da = 32'h0; wd = 32'h0; we = 4'h0;
    for (int c = 0; c < 3000; c++) begin
      if (!i_pend && $urandom_range(0, 2) == 0) begin
        i_pend = 1'b1;
        ia = ($urandom() & 32'hFFFF_C000) | (32'($urandom_range(0, 15)) << 2) | ($urandom() & 32'h3);
      end
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1'b1;
        da = ($urandom() & 32'hFFFF_C000) | (32'($urandom_range(0, 15)) << 2) | ($urandom() & 32'h3);
        we = ($urandom_range(0, 1) == 1) ? 4'($urandom()) : 4'h0;
        wd = $urandom();
      end
      bus.i_req_valid  = i_pend; bus.i_req_addr = ia;
      bus.d_req_valid  = d_pend; bus.d_req_addr = da;
      bus.d_req_we     = we;     bus.d_req_wdata = wd;
      bus.i_resp_ready = ($urandom_range(0, 3) != 0);
      bus.d_resp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      check("rnd_busy", 32'(bus.busy), 32'(busy_m));
      if (busy_m) begin
        check("rnd_no_ready", 32'({bus.i_req_ready, bus.d_req_ready}), 32'h0);
        check("rnd_rv_i", 32'(bus.i_resp_valid), 32'(!exp_side));
        check("rnd_rv_d", 32'(bus.d_resp_valid), 32'(exp_side));
        check("rnd_data",  exp_side ? bus.d_resp_data : bus.i_resp_data, exp_data);
        check("rnd_other", exp_side ? bus.i_resp_data : bus.d_resp_data, 32'h0);
        check("rnd_quiet_en", 32'(bus.mem_en), 32'h0);
        if (exp_side ? bus.d_resp_ready : bus.i_resp_ready) busy_m = 1'b0;
      end else begin
        check("rnd_idle_rv", 32'({bus.i_resp_valid, bus.d_resp_valid}), 32'h0);
        if (i_pend || d_pend) begin
          winner = d_pend;
          addr   = winner ? da : ia;
          word   = addr[13:2];
          check("rnd_grant_d", 32'(bus.d_req_ready), 32'(winner));
          check("rnd_grant_i", 32'(bus.i_req_ready), 32'(!winner));
          check("rnd_mem_en",  32'(bus.mem_en),      32'h1);
          check("rnd_mem_addr", 32'(bus.mem_addr),   32'(word));
          check("rnd_mem_we",  32'(bus.mem_we),      winner ? 32'(we) : 32'h0);
          if (winner && we != 4'h0) begin
            for (int b = 0; b < 4; b++)
              if (we[b]) model[word[3:0]][8*b +: 8] = wd[8*b +: 8];
            exp_data = 32'h0;
          end else begin
            exp_data = model[word[3:0]];
          end
          exp_side = winner;
          busy_m   = 1'b1;
          if (winner) d_pend = 1'b0;
          else        i_pend = 1'b0;
        end else begin
          check("rnd_idle_en", 32'({bus.mem_en, bus.i_req_ready, bus.d_req_ready}), 32'h0);
        end
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
